// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched
// Shared iterative binary-to-BCD converter (shift-and-add3, "double dabble")
// with a two-input round-robin front end and a tagged valid/ready result port.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req0_valid/data/ready requester 0 operand handshake (ready is combinational)
//   req1_valid/data/ready requester 1 operand handshake (ready is combinational)
//   out_valid/out_ready   result handshake
//   out_id                requester owning the result
//   out_bcd               BCD digits, [3:0] is the least significant digit
//   busy                  engine is converting or holding a result
module bcd_conv_sched #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [WIDTH-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  req1_ready,
    output logic                  out_valid,
    output logic                  out_id,
    output logic [4*DIGITS-1:0]   out_bcd,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    shift_reg;
    logic [BW-1:0]       digits_reg;
    logic [CW-1:0]       cnt_reg;
    logic                id_reg;
    logic                last_grant_reg;
    logic [BW-1:0]       out_bcd_reg;
    logic                out_id_reg;

    logic                grant;
    logic                accept;
    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;

    // req1 wins when it is alone, or when both ask and req0 was served last.
    assign grant  = req1_valid & (~req0_valid | ~last_grant_reg);
    assign req0_ready = (state_reg == IDLE) & ~grant;
    assign req1_ready = (state_reg == IDLE) & grant;
    assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Add 3 to every digit that would overflow past 9 after the doubling shift.
    // A digit is at most 9 here, so 9+3 still fits in 4 bits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign adj[4*gi +: 4] = (digits_reg[4*gi +: 4] >= 4'd5)
                                  ? digits_reg[4*gi +: 4] + 4'd3
                                  : digits_reg[4*gi +: 4];
        end
    endgenerate

    // The top bit shifted out is always zero because 10**DIGITS > 2**WIDTH-1.
    assign shifted = {adj, shift_reg} << 1;

    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_bcd   = out_bcd_reg;
    assign out_id    = out_id_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg      <= '0;
            digits_reg     <= '0;
            cnt_reg        <= '0;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
            out_bcd_reg    <= '0;
            out_id_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg      <= grant ? req1_data : req0_data;
                        digits_reg     <= '0;
                        cnt_reg        <= CW'(WIDTH);
                        id_reg         <= grant;
                        last_grant_reg <= grant;
                    end
                end
                SHIFT: begin
                    shift_reg  <= shifted[WIDTH-1:0];
                    digits_reg <= shifted[BW+WIDTH-1:WIDTH];
                    cnt_reg    <= cnt_reg - CW'(1);
                    // Publish the result only on the final shift so out_bcd
                    // keeps the previous result during a conversion.
                    if (cnt_reg == CW'(1)) begin
                        out_bcd_reg <= shifted[BW+WIDTH-1:WIDTH];
                        out_id_reg  <= id_reg;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_sched.sv
module tb_bcd_conv_sched;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic [WIDTH-1:0]  req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              out_valid, out_id, out_ready, busy;
    logic [4*DIGITS-1:0] out_bcd;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state (spec-level: phase, cycles remaining, result)
    int              m_phase;      // 0 idle, 1 converting, 2 holding result
    int              m_left;
    int              m_last_grant;
    int              m_id;
    int              m_val;
    logic [4*DIGITS-1:0] m_out_bcd;
    int              m_out_id;
    int              n_results;

    bcd_conv_sched #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_id(out_id), .out_bcd(out_bcd),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int exp_grant();
        return (req1_valid && (!req0_valid || m_last_grant == 0)) ? 1 : 0;
    endfunction

    task automatic check_outputs();
        int g;
        g = exp_grant();
        chk("req0_ready", 32'(req0_ready), (m_phase == 0 && g == 0) ? 1 : 0);
        chk("req1_ready", 32'(req1_ready), (m_phase == 0 && g == 1) ? 1 : 0);
        chk("busy",       32'(busy),       (m_phase != 0) ? 1 : 0);
        chk("out_valid",  32'(out_valid),  (m_phase == 2) ? 1 : 0);
        chk("out_bcd",    32'(out_bcd),    32'(m_out_bcd));
        chk("out_id",     32'(out_id),     32'(m_out_id));
    endtask

    task automatic model_edge();
        int g;
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_last_grant = 1;
            m_out_bcd = '0; m_out_id = 0;
        end else begin
            case (m_phase)
                0: begin
                    g = exp_grant();
                    if ((g == 0 && req0_valid) || (g == 1 && req1_valid)) begin
                        m_id = g;
                        m_val = (g == 1) ? int'(req1_data) : int'(req0_data);
                        m_last_grant = g;
                        m_left = WIDTH;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_out_bcd = to_bcd(m_val);
                        m_out_id = m_id;
                    end
                end
                default: begin
                    if (out_ready) begin
                        m_phase = 0;
                        n_results++;
                        $display("result id=%0d value=%0d bcd=%h", m_out_id, m_val, m_out_bcd);
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int id, input int val);
        if (id == 0) begin req0_valid = 1'b1; req0_data = 16'(val); end
        else         begin req1_valid = 1'b1; req1_data = 16'(val); end
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        n_results = 0;
        m_phase = 0; m_left = 0; m_last_grant = 1; m_id = 0; m_val = 0;
        m_out_bcd = '0; m_out_id = 0;
        rst_n = 1'b0; out_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        @(posedge clk); #1;
        run(2);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Full-scale operand, then zero and 9999 from requester 1
        send(0, 16'hFFFF); run(20);
        send(1, 0);        run(20);
        send(1, 9999);     run(20);

        // Contention: both held valid; should alternate req0, req1, req0
        req0_valid = 1'b1; req0_data = 16'h1234;
        req1_valid = 1'b1; req1_data = 16'h00FF;
        run(3 * (WIDTH + 2) + 2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(20);

        // Consumer stalls in DONE while the other requester waits
        out_ready = 1'b0;
        send(0, 16'h0ABC);
        req1_valid = 1'b1; req1_data = 16'h7777;
        run(WIDTH + 10);
        out_ready = 1'b1;
        run(WIDTH + 6);
        req1_valid = 1'b0;
        run(20);

        // Reset in the middle of a conversion, then contention after reset
        send(0, 16'hBEEF);
        run(8);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        run(2);
        req0_valid = 1'b1; req0_data = 16'd12345;
        req1_valid = 1'b1; req1_data = 16'd54321;
        cycle();
        req0_valid = 1'b0;
        run(2 * (WIDTH + 2) + 2);
        req1_valid = 1'b0;
        run(20);

        // Randomized traffic: data toggles freely, valids/ready random
        for (int i = 0; i < 4000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = 16'($urandom_range(0, 65535));
            req1_data  = 16'($urandom_range(0, 65535));
            out_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        run(WIDTH + 4);

        chk("results_seen", 32'(n_results > 50), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
